// File: rtl/ls_phase_scheduler_pkg.sv
// Shared types and the rotate-priority pick helper for the load/store phase scheduler.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package ls_sched_pkg;

    typedef enum logic [1:0] {
        LS_IDLE  = 2'd0,
        LS_FILL  = 2'd1,
        LS_DRAIN = 2'd2
    } ls_phase_t;

    // Upper bound on requesters; the pick helper works on this fixed width.
    localparam int MAX_REQ = 16;

    // One-hot pick of the first set bit of elig, searching upward from ptr
    // and wrapping at n. Returns zero when nothing is eligible.
    function automatic logic [MAX_REQ-1:0] rr_onehot(
        input logic [MAX_REQ-1:0] elig,
        input logic [3:0]         ptr,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [4:0]         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                idx = {1'b0, ptr} + 5'(k);
                if (idx >= 5'(n)) begin
                    idx = idx - 5'(n);
                end
                if (elig[idx[3:0]]) begin
                    pick[idx[3:0]] = 1'b1;
                    found          = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ls_phase_scheduler_if.sv
// Request/grant and status bundle between requesters and the phase scheduler.
// Latency: wires only.
// Backpressure: req is held by the requester until its gnt bit is seen.
interface ls_phase_scheduler_if #(
    parameter int NREQ = 4,
    parameter int CAP  = 25000
);
    import ls_sched_pkg::*;

    localparam int VBITS = $clog2(CAP + 1);

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  dir;
    logic [NREQ-1:0]  gnt;
    logic [VBITS-1:0] vol;
    logic             full;
    logic             empty;
    ls_phase_t        phase;

    modport master (output req, dir, input gnt, vol, full, empty, phase);
    modport slave  (input req, dir, output gnt, vol, full, empty, phase);

endinterface

// File: rtl/ls_phase_scheduler_rr_pick.sv
// Round-robin one-hot pick among eligible requesters, starting at ptr.
// Latency: combinational.
// Backpressure: none; valid is low when no requester is eligible.
module ls_rr_pick
    import ls_sched_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PBITS = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  elig,
    input  logic [PBITS-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [PBITS-1:0] index,
    output logic             valid
);

    logic [MAX_REQ-1:0] pick_wide;

    // Widen to the helper's fixed width, pick, then encode the index.
    always_comb begin
        pick_wide = rr_onehot(MAX_REQ'(elig), 4'(ptr), NREQ);
        onehot    = pick_wide[NREQ-1:0];
        valid     = |onehot;
        index     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (onehot[i]) begin
                index = PBITS'(i);
            end
        end
    end

endmodule

// File: rtl/ls_phase_scheduler.sv
// Load/store volume scheduler: FILL/DRAIN phases with hysteresis, round-robin within a phase.
// Latency: gnt/vol/flags registered, one edge after the deciding cycle; IDLE costs one extra cycle.
// Backpressure: requests wait (held req) while the opposite phase runs; optional SVA via LS_SCHED_PROPS_EN.
module ls_phase_scheduler
    import ls_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CAP  = 25000
) (
    input  logic                  clk,
    input  logic                  rst,
    ls_phase_scheduler_if.slave   bus
);

    localparam int               VBITS = $clog2(CAP + 1);
    localparam int               PBITS = $clog2(NREQ);
    localparam logic [VBITS-1:0] CAP_V = VBITS'(CAP);

    ls_phase_t        phase_q, phase_d;
    logic [VBITS-1:0] vol_q, vol_d;
    logic [PBITS-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             full_q, empty_q;

    logic [NREQ-1:0]  elig_load, elig_store, pick_mask, pick_oh;
    logic [PBITS-1:0] pick_idx, ptr_after;
    logic             pick_vld, at_cap, at_zero;

    // A requester granted at the last edge is still holding req; mask it out.
    assign elig_load  = bus.req &  bus.dir & ~gnt_q;
    assign elig_store = bus.req & ~bus.dir & ~gnt_q;
    assign pick_mask  = (phase_q == LS_DRAIN) ? elig_store : elig_load;
    assign at_cap     = (vol_q == CAP_V);
    assign at_zero    = (vol_q == '0);
    assign ptr_after  = (pick_idx == PBITS'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    ls_rr_pick #(.NREQ(NREQ), .PBITS(PBITS)) u_pick (
        .elig   (pick_mask),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .index  (pick_idx),
        .valid  (pick_vld)
    );

    // Phase decisions; grants only inside FILL/DRAIN so IDLE never grants.
    always_comb begin
        phase_d = phase_q;
        vol_d   = vol_q;
        ptr_d   = ptr_q;
        gnt_d   = '0;
        case (phase_q)
            LS_IDLE: begin
                if (|elig_load && !at_cap) begin
                    phase_d = LS_FILL;
                end else if (|elig_store && !at_zero) begin
                    phase_d = LS_DRAIN;
                end
            end
            LS_FILL: begin
                if (at_cap) begin
                    phase_d = (|elig_store) ? LS_DRAIN : LS_IDLE;
                end else if (pick_vld) begin
                    gnt_d = pick_oh;
                    vol_d = vol_q + 1'b1;
                    ptr_d = ptr_after;
                end else begin
                    phase_d = (|elig_store) ? LS_DRAIN : LS_IDLE;
                end
            end
            LS_DRAIN: begin
                if (at_zero) begin
                    phase_d = (|elig_load) ? LS_FILL : LS_IDLE;
                end else if (pick_vld) begin
                    gnt_d = pick_oh;
                    vol_d = vol_q - 1'b1;
                    ptr_d = ptr_after;
                end else begin
                    phase_d = (|elig_load) ? LS_FILL : LS_IDLE;
                end
            end
            default: begin
                phase_d = LS_IDLE;
            end
        endcase
    end

    // State register; flags follow the next volume so they move with vol.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= LS_IDLE;
            vol_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            vol_q   <= vol_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            full_q  <= (vol_d == CAP_V);
            empty_q <= (vol_d == '0);
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.vol   = vol_q;
    assign bus.full  = full_q;
    assign bus.empty = empty_q;
    assign bus.phase = phase_q;

`ifdef LS_SCHED_PROPS_EN
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_vol_bound:   assert property (@(posedge clk) disable iff (rst) vol_q <= CAP_V);
    a_full_flag:   assert property (@(posedge clk) disable iff (rst) full_q == (vol_q == CAP_V));
    a_idle_nognt:  assert property (@(posedge clk) disable iff (rst) (phase_q == LS_IDLE) |=> (gnt_q == '0));
    for (genvar i = 0; i < NREQ; i++) begin : g_props
        a_gnt_req:  assert property (@(posedge clk) disable iff (rst) gnt_q[i] |-> $past(bus.req[i]));
        m_req_hold: assume property (@(posedge clk) disable iff (rst) bus.req[i] && !gnt_q[i] |=> bus.req[i]);
        a_live:     assert property (@(posedge clk) disable iff (rst) bus.req[i] |-> s_eventually gnt_q[i]);
    end
`else
    // Properties are compiled only when LS_SCHED_PROPS_EN is defined.
`endif

endmodule
